// File: rtl/instr_stream_encoder.sv
// RV32I instruction encoder and imem preloader.
// Takes decoded field bundles over a valid/ready stream, packs each into a
// 32-bit instruction word and writes it to consecutive word addresses.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | after reset, waiting for start
//   LOAD  | accepting bundles, issuing writes
//   DRAIN | no more bundles accepted, waiting for the pending write to retire
//   DONE  | session finished, holds until the next start

module instr_stream_encoder #(
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
   parameter int                DEPTH     = 64,
   localparam int               CNT_W     = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_fmt,
   input  logic [6:0]        in_op,
   input  logic [2:0]        in_funct3,
   input  logic              in_funct7b5,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [31:0]       in_imm,
   input  logic              in_last,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic              mem_ready,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [CNT_W-1:0]  count
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [2:0] FMT_R = 3'd0;
   localparam logic [2:0] FMT_I = 3'd1;
   localparam logic [2:0] FMT_S = 3'd2;
   localparam logic [2:0] FMT_B = 3'd3;
   localparam logic [2:0] FMT_U = 3'd4;
   localparam logic [2:0] FMT_J = 3'd5;

   localparam logic [6:0] OP_IMM = 7'b0010011;

   state_t              state_q, state_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [31:0]         mem_wdata_q, mem_wdata_d;
   logic                err_q, err_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [CNT_W-1:0]    idx_q, idx_d;

   logic [31:0]         enc_word;
   logic                enc_legal;
   logic                enc_misalign;
   logic                is_shift;
   logic                accept;
   logic                retire;
   logic                slot_free;
   logic                room_left;

   // The output stage can take a new word when empty or when it drains this edge.
   assign slot_free = !mem_we_q || mem_ready;
   assign room_left = (idx_q < CNT_W'(DEPTH));
   assign in_ready  = (state_q == S_LOAD) && slot_free && room_left;
   assign accept    = in_valid && in_ready;
   assign retire    = mem_we_q && mem_ready;

   // Pack the field bundle into an RV32I word according to its format.
   always_comb begin
      enc_word     = '0;
      enc_legal    = 1'b1;
      enc_misalign = 1'b0;
      is_shift     = (in_op == OP_IMM) &&
                     ((in_funct3 == 3'b001) || (in_funct3 == 3'b101));
      case (in_fmt)
         FMT_R: begin
            enc_word = {1'b0, in_funct7b5, 5'b00000, in_rs2, in_rs1,
                        in_funct3, in_rd, in_op};
         end
         FMT_I: begin
            // Shift-immediates carry funct7 in the upper immediate bits.
            if (is_shift) begin
               enc_word = {1'b0, in_funct7b5, 5'b00000, in_imm[4:0], in_rs1,
                           in_funct3, in_rd, in_op};
            end else begin
               enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_op};
            end
         end
         FMT_S: begin
            enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3,
                        in_imm[4:0], in_op};
         end
         FMT_B: begin
            enc_word     = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:1], in_imm[11], in_op};
            enc_misalign = in_imm[0];
         end
         FMT_U: begin
            enc_word = {in_imm[31:12], in_rd, in_op};
         end
         FMT_J: begin
            enc_word     = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                            in_rd, in_op};
            enc_misalign = in_imm[0];
         end
         default: begin
            enc_legal = 1'b0;
         end
      endcase
   end

   // Next-state, write-stage and session bookkeeping.
   always_comb begin
      state_d     = state_q;
      mem_we_d    = mem_we_q && !mem_ready;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      err_d       = err_q;
      idx_d       = idx_q;
      count_d     = retire ? (count_q + CNT_W'(1)) : count_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d    = S_LOAD;
               count_d    = '0;
               err_d      = 1'b0;
               idx_d      = '0;
               mem_addr_d = BASE_ADDR;
            end
         end

         S_LOAD: begin
            if (accept) begin
               if (enc_legal) begin
                  mem_we_d    = 1'b1;
                  mem_addr_d  = BASE_ADDR + ADDR_W'({idx_q, 2'b00});
                  mem_wdata_d = enc_word;
                  idx_d       = idx_q + CNT_W'(1);
                  if (enc_misalign) begin
                     err_d = 1'b1;
                  end
               end else begin
                  err_d = 1'b1;
               end

               // An explicit last wins over running out of room on the same bundle.
               if (in_last) begin
                  state_d = S_DRAIN;
               end else if (enc_legal && (idx_q == CNT_W'(DEPTH - 1))) begin
                  state_d = S_DRAIN;
                  err_d   = 1'b1;
               end
            end
         end

         S_DRAIN: begin
            if (slot_free) begin
               state_d = S_DONE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset drops any pending write.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= BASE_ADDR;
         mem_wdata_q <= '0;
         err_q       <= 1'b0;
         count_q     <= '0;
         idx_q       <= '0;
      end else begin
         state_q     <= state_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         err_q       <= err_d;
         count_q     <= count_d;
         idx_q       <= idx_d;
      end
   end

   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = (state_q == S_LOAD) || (state_q == S_DRAIN);
   assign done      = (state_q == S_DONE);
   assign err       = err_q;
   assign count     = count_q;

endmodule

// File: tb/tb_instr_stream_encoder.sv
// Bench for instr_stream_encoder: directed vectors plus randomized sessions
// checked against a field-level reference model of the encoder.

module tb_instr_stream_encoder;

   localparam int          ADDR_W = 32;
   localparam int          DEPTH  = 4;
   localparam logic [31:0] BASE   = 32'h0000_0100;
   localparam int          CNT_W  = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [2:0]  fmt;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic        f7;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
      logic        last;
   } bundle_t;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic              in_valid;
   logic              in_ready;
   logic [2:0]        in_fmt;
   logic [6:0]        in_op;
   logic [2:0]        in_funct3;
   logic              in_funct7b5;
   logic [4:0]        in_rd;
   logic [4:0]        in_rs1;
   logic [4:0]        in_rs2;
   logic [31:0]       in_imm;
   logic              in_last;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              mem_ready;
   logic              busy;
   logic              done;
   logic              err;
   logic [CNT_W-1:0]  count;

   int n_checks = 0;
   int n_fail   = 0;

   bundle_t     stim[$];
   logic [31:0] exp_addr[$];
   logic [31:0] exp_data[$];
   int          exp_consumed;
   logic        exp_err;
   logic        exp_last_legal;
   logic [31:0] obs_addr[$];
   logic [31:0] obs_data[$];
   int          obs_cyc[$];
   int          stall_cnt;

   instr_stream_encoder #(
      .ADDR_W    (ADDR_W),
      .BASE_ADDR (BASE),
      .DEPTH     (DEPTH)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_fmt      (in_fmt),
      .in_op       (in_op),
      .in_funct3   (in_funct3),
      .in_funct7b5 (in_funct7b5),
      .in_rd       (in_rd),
      .in_rs1      (in_rs1),
      .in_rs2      (in_rs2),
      .in_imm      (in_imm),
      .in_last     (in_last),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_ready   (mem_ready),
      .busy        (busy),
      .done        (done),
      .err         (err),
      .count       (count)
   );

   always #5 clk = ~clk;

   function automatic bundle_t mk(input logic [2:0] fmt, input logic [6:0] op,
                                  input logic [2:0] f3, input logic f7,
                                  input logic [4:0] rd, input logic [4:0] rs1,
                                  input logic [4:0] rs2, input logic [31:0] imm,
                                  input logic last);
      bundle_t b;
      b.fmt = fmt; b.op = op; b.f3 = f3; b.f7 = f7;
      b.rd = rd; b.rs1 = rs1; b.rs2 = rs2; b.imm = imm; b.last = last;
      return b;
   endfunction

   // Reference encoder: each field shifted into its ISA bit position.
   function automatic logic [31:0] ref_encode(input bundle_t b);
      logic [31:0] op, rd, f3, rs1, rs2, f7, imm, w;
      op  = 32'(b.op);
      rd  = 32'(b.rd)  << 7;
      f3  = 32'(b.f3)  << 12;
      rs1 = 32'(b.rs1) << 15;
      rs2 = 32'(b.rs2) << 20;
      f7  = 32'(b.f7)  << 30;
      imm = b.imm;
      w   = 32'h0;
      case (b.fmt)
         3'd0: w = op | rd | f3 | rs1 | rs2 | f7;
         3'd1: begin
            if (b.op == 7'h13 && (b.f3 == 3'd1 || b.f3 == 3'd5))
               w = op | rd | f3 | rs1 | ((imm & 32'h1F) << 20) | f7;
            else
               w = op | rd | f3 | rs1 | ((imm & 32'hFFF) << 20);
         end
         3'd2: w = op | ((imm & 32'h1F) << 7) | f3 | rs1 | rs2 |
                   (((imm >> 5) & 32'h7F) << 25);
         3'd3: w = op | (((imm >> 11) & 32'h1) << 7) | (((imm >> 1) & 32'hF) << 8) |
                   f3 | rs1 | rs2 | (((imm >> 5) & 32'h3F) << 25) |
                   (((imm >> 12) & 32'h1) << 31);
         3'd4: w = op | rd | (imm & 32'hFFFFF000);
         3'd5: w = op | rd | (((imm >> 12) & 32'hFF) << 12) |
                   (((imm >> 11) & 32'h1) << 20) | (((imm >> 1) & 32'h3FF) << 21) |
                   (((imm >> 20) & 32'h1) << 31);
         default: w = 32'h0;
      endcase
      return w;
   endfunction

   // Session model: which bundles are consumed, which words land where, and err.
   task automatic model_session();
      int idx;
      exp_addr.delete();
      exp_data.delete();
      exp_consumed   = 0;
      exp_err        = 1'b0;
      exp_last_legal = 1'b0;
      idx            = 0;
      for (int k = 0; k < stim.size(); k++) begin
         exp_consumed++;
         if (stim[k].fmt > 3'd5) begin
            exp_err        = 1'b1;
            exp_last_legal = 1'b0;
            if (stim[k].last) break;
            continue;
         end
         exp_addr.push_back(BASE + 32'(4 * idx));
         exp_data.push_back(ref_encode(stim[k]));
         idx++;
         exp_last_legal = 1'b1;
         if ((stim[k].fmt == 3'd3 || stim[k].fmt == 3'd5) && stim[k].imm[0])
            exp_err = 1'b1;
         if (stim[k].last) break;
         if (idx == DEPTH) begin
            exp_err = 1'b1;
            break;
         end
      end
   endtask

   task automatic drive_bundle(input bundle_t b);
      in_fmt = b.fmt; in_op = b.op; in_funct3 = b.f3; in_funct7b5 = b.f7;
      in_rd = b.rd; in_rs1 = b.rs1; in_rs2 = b.rs2; in_imm = b.imm; in_last = b.last;
   endtask

   // Runs one session over stim[], sampling on the falling edge.
   task automatic run_session(input int vpct, input int rpct, input int stall_at,
                              input string tag);
      int          i, cyc, last_ret, done_cyc;
      logic        stall_prev, done_seen;
      logic [31:0] p_addr, p_data;
      model_session();
      obs_addr.delete(); obs_data.delete(); obs_cyc.delete();
      stall_cnt  = 0;
      i          = 0;
      cyc        = 0;
      last_ret   = -10;
      done_cyc   = -1;
      stall_prev = 1'b0;
      done_seen  = 1'b0;
      p_addr     = '0;
      p_data     = '0;
      in_valid   = 1'b0;
      start      = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      while (!done_seen && cyc < 300) begin
         if (cyc >= stall_at && cyc < stall_at + 3) mem_ready = 1'b0;
         else mem_ready = ($urandom_range(99) < rpct);
         if (i < stim.size() && $urandom_range(99) < vpct) begin
            in_valid = 1'b1;
            drive_bundle(stim[i]);
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         if (stall_prev) begin
            n_checks++;
            if (mem_we !== 1'b1 || mem_addr !== p_addr || mem_wdata !== p_data) begin
               n_fail++;
               $display("FAIL %s stall_hold: got we=%b addr=%h data=%h expected we=1 addr=%h data=%h",
                        tag, mem_we, mem_addr, mem_wdata, p_addr, p_data);
            end
         end
         if (mem_we && !mem_ready) begin
            stall_cnt++;
            n_checks++;
            if (in_ready !== 1'b0) begin
               n_fail++;
               $display("FAIL %s stall_in_ready: got %b expected 0", tag, in_ready);
            end
         end
         if (mem_we && mem_ready) begin
            obs_addr.push_back(mem_addr);
            obs_data.push_back(mem_wdata);
            obs_cyc.push_back(cyc);
            last_ret = cyc;
         end
         if (in_valid && in_ready) i++;
         if (done) begin
            done_seen = 1'b1;
            done_cyc  = cyc;
         end
         stall_prev = mem_we && !mem_ready;
         p_addr     = mem_addr;
         p_data     = mem_wdata;
         @(posedge clk); #1;
         cyc++;
      end
      in_valid = 1'b0;

      n_checks++;
      if (!done_seen) begin
         n_fail++;
         $display("FAIL %s timeout: done not seen within %0d cycles", tag, cyc);
      end
      n_checks++;
      if (i != exp_consumed) begin
         n_fail++;
         $display("FAIL %s consumed: got %0d expected %0d", tag, i, exp_consumed);
      end
      n_checks++;
      if (obs_addr.size() != exp_addr.size()) begin
         n_fail++;
         $display("FAIL %s writes: got %0d expected %0d", tag, obs_addr.size(), exp_addr.size());
      end
      for (int k = 0; k < exp_addr.size() && k < obs_addr.size(); k++) begin
         n_checks++;
         if (obs_addr[k] !== exp_addr[k] || obs_data[k] !== exp_data[k]) begin
            n_fail++;
            $display("FAIL %s word%0d: got addr=%h data=%h expected addr=%h data=%h",
                     tag, k, obs_addr[k], obs_data[k], exp_addr[k], exp_data[k]);
         end
      end
      n_checks++;
      if (err !== exp_err) begin
         n_fail++;
         $display("FAIL %s err: got %b expected %b", tag, err, exp_err);
      end
      n_checks++;
      if (count !== CNT_W'(exp_addr.size())) begin
         n_fail++;
         $display("FAIL %s count: got %0d expected %0d", tag, count, exp_addr.size());
      end
      n_checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL %s end_state: got done=%b busy=%b expected done=1 busy=0", tag, done, busy);
      end
      if (exp_last_legal && done_seen) begin
         n_checks++;
         if (done_cyc != last_ret + 1) begin
            n_fail++;
            $display("FAIL %s done_timing: got cycle %0d expected %0d", tag, done_cyc, last_ret + 1);
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (in_ready !== 1'b0 || mem_we !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_hs: got in_ready=%b mem_we=%b expected 0 0", in_ready, mem_we);
      end
      n_checks++;
      if (mem_addr !== BASE || mem_wdata !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_mem: got addr=%h data=%h expected %h 0", mem_addr, mem_wdata, BASE);
      end
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || count !== '0) begin
         n_fail++;
         $display("FAIL reset_status: got busy=%b done=%b err=%b count=%0d expected 0", busy, done, err, count);
      end
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_hold: got busy=%b done=%b in_ready=%b expected 0", busy, done, in_ready);
      end
   endtask

   task automatic test_vectors();
      logic [31:0] want[4];
      want[0] = 32'h002081B3; want[1] = 32'h402081B3;
      want[2] = 32'hFE208EE3; want[3] = 32'h008000EF;
      stim.delete();
      stim.push_back(mk(3'd0, 7'b0110011, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'h0, 1'b0));
      stim.push_back(mk(3'd0, 7'b0110011, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'h0, 1'b0));
      stim.push_back(mk(3'd3, 7'b1100011, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 1'b0));
      stim.push_back(mk(3'd5, 7'b1101111, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8, 1'b1));
      run_session(100, 100, -10, "vectors");
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if (obs_data.size() <= k) begin
            n_fail++;
            $display("FAIL vec%0d: missing word, expected %h", k, want[k]);
         end else if (obs_data[k] !== want[k] || obs_addr[k] !== BASE + 32'(4 * k)) begin
            n_fail++;
            $display("FAIL vec%0d: got addr=%h data=%h expected addr=%h data=%h",
                     k, obs_addr[k], obs_data[k], BASE + 32'(4 * k), want[k]);
         end
      end
      stim.delete();
      stim.push_back(mk(3'd1, 7'b0010011, 3'd5, 1'b1, 5'd5, 5'd6, 5'd0, 32'd3, 1'b1));
      run_session(100, 100, -10, "srai");
      n_checks++;
      if (obs_data.size() != 1 || obs_data[0] !== 32'h40335293) begin
         n_fail++;
         $display("FAIL srai_word: got %0d words first=%h expected 1 word 40335293",
                  obs_data.size(), (obs_data.size() > 0) ? obs_data[0] : 32'hx);
      end
   endtask

   task automatic test_session_end();
      stim.delete();
      for (int k = 0; k < 3; k++)
         stim.push_back(mk(3'd1, 7'b0010011, 3'd0, 1'b0, 5'(k + 1), 5'd0, 5'd0, 32'(k * 16), k == 2));
      run_session(100, 100, -10, "session_end");
      for (int k = 1; k < obs_cyc.size(); k++) begin
         n_checks++;
         if (obs_cyc[k] != obs_cyc[k - 1] + 1) begin
            n_fail++;
            $display("FAIL throughput%0d: got retire cycle %0d expected %0d", k, obs_cyc[k], obs_cyc[k - 1] + 1);
         end
      end
   endtask

   task automatic test_backpressure();
      stim.delete();
      for (int k = 0; k < 4; k++)
         stim.push_back(mk(3'd2, 7'b0100011, 3'd2, 1'b0, 5'd0, 5'(k), 5'(k + 7), 32'($urandom), k == 3));
      run_session(100, 100, 2, "backpressure");
      n_checks++;
      if (stall_cnt != 3) begin
         n_fail++;
         $display("FAIL bp_stalls: got %0d stalled cycles expected 3", stall_cnt);
      end
   endtask

   task automatic test_depth();
      stim.delete();
      for (int k = 0; k < 5; k++)
         stim.push_back(mk(3'd4, 7'b0110111, 3'd0, 1'b0, 5'(k), 5'd0, 5'd0, 32'($urandom), 1'b0));
      run_session(100, 100, -10, "depth");
   endtask

   task automatic test_errors();
      stim.delete();
      stim.push_back(mk(3'd0, 7'b0110011, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'h0, 1'b0));
      stim.push_back(mk(3'd7, 7'b0110011, 3'd0, 1'b0, 5'd9, 5'd9, 5'd9, 32'h0, 1'b0));
      stim.push_back(mk(3'd0, 7'b0110011, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'h0, 1'b1));
      run_session(70, 70, -10, "illegal_fmt");
      n_checks++;
      if (obs_addr.size() != 2 || obs_addr[1] !== BASE + 32'd4 || obs_data[1] !== 32'h402081B3) begin
         n_fail++;
         $display("FAIL illegal_skip: got %0d words expected 2 with second at %h = 402081b3",
                  obs_addr.size(), BASE + 32'd4);
      end
      stim.delete();
      stim.push_back(mk(3'd3, 7'b1100011, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd3, 1'b1));
      run_session(100, 100, -10, "b_misalign");
      n_checks++;
      if (obs_data.size() != 1 || obs_data[0] !== 32'h00208163 || err !== 1'b1) begin
         n_fail++;
         $display("FAIL b_misalign_word: got %0d words err=%b expected 1 word 00208163 err=1",
                  obs_data.size(), err);
      end
      stim.delete();
      stim.push_back(mk(3'd4, 7'b0010111, 3'd0, 1'b0, 5'd4, 5'd0, 5'd0, 32'h12345000, 1'b0));
      stim.push_back(mk(3'd6, 7'b0000000, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b1));
      run_session(80, 60, -10, "illegal_last");
   endtask

   task automatic test_reset_mid_stall();
      bundle_t b;
      b = mk(3'd0, 7'b0110011, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'h0, 1'b1);
      start = 1'b1;
      @(posedge clk); #1;
      start     = 1'b0;
      mem_ready = 1'b0;
      in_valid  = 1'b1;
      drive_bundle(b);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (mem_we !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_stall_setup: got mem_we=%b expected 1", mem_we);
      end
      #2 reset = 1'b1;
      #1;
      n_checks++;
      if (mem_we !== 1'b0 || mem_addr !== BASE || mem_wdata !== 32'h0) begin
         n_fail++;
         $display("FAIL async_reset_mem: got we=%b addr=%h data=%h expected 0 %h 0",
                  mem_we, mem_addr, mem_wdata, BASE);
      end
      n_checks++;
      if (busy !== 1'b0 || count !== '0 || in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset_status: got busy=%b count=%0d in_ready=%b expected 0",
                  busy, count, in_ready);
      end
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      stim.delete();
      stim.push_back(mk(3'd2, 7'b0100011, 3'd2, 1'b0, 5'd0, 5'd8, 5'd9, 32'h7F4, 1'b0));
      stim.push_back(mk(3'd4, 7'b0110111, 3'd0, 1'b0, 5'd10, 5'd0, 5'd0, 32'hABCDE000, 1'b1));
      run_session(100, 100, -10, "after_reset");
      n_checks++;
      if (obs_addr.size() == 0 || obs_addr[0] !== BASE) begin
         n_fail++;
         $display("FAIL restart_addr: got %0d words expected first at %h", obs_addr.size(), BASE);
      end
   endtask

   task automatic gen_bundle(output bundle_t b);
      int r;
      r = int'($urandom_range(99));
      b.fmt = (r < 6) ? 3'(6 + $urandom_range(1)) : 3'($urandom_range(5));
      b.op  = 7'($urandom);
      if (b.fmt == 3'd1 && $urandom_range(1) == 1) b.op = 7'b0010011;
      b.f3  = 3'($urandom);
      b.f7  = 1'($urandom);
      b.rd  = 5'($urandom);
      b.rs1 = 5'($urandom);
      b.rs2 = 5'($urandom);
      b.imm = $urandom;
      if ((b.fmt == 3'd3 || b.fmt == 3'd5) && $urandom_range(9) != 0) b.imm[0] = 1'b0;
      b.last = 1'b0;
   endtask

   task automatic test_random();
      bundle_t b;
      int      len, lastpos;
      for (int s = 0; s < 30; s++) begin
         stim.delete();
         len     = int'($urandom_range(6, 1));
         lastpos = ($urandom_range(9) < 7) ? int'($urandom_range(len - 1)) : -1;
         if (lastpos < 0) len = 7;
         for (int k = 0; k < len; k++) begin
            gen_bundle(b);
            b.last = (k == lastpos) || (k == len - 1);
            stim.push_back(b);
         end
         run_session(int'($urandom_range(100, 30)), int'($urandom_range(100, 30)),
                     -10, $sformatf("rand%0d", s));
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; in_valid = 1'b0; mem_ready = 1'b0;
      in_fmt = '0; in_op = '0; in_funct3 = '0; in_funct7b5 = 1'b0;
      in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0; in_last = 1'b0;
      test_reset();
      test_vectors();
      test_session_end();
      test_backpressure();
      test_depth();
      test_errors();
      test_reset_mid_stall();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
